id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised instruction-decode stage for the five-stage MIPS core. It decodes the fetched word and reads the register file with WB write-through. It forwards EX/MEM results, detects load-use and branch-operand hazards, and resolves the full branch/jump set in ID (delay-slot semantics). Results are registered into the ID/EX pipeline register, and the block counts stall cycles. It sits between the IF/ID register and EX.

## Interface
Parameters:
- DATA_W, 32, datapath width (instruction width fixed at 32)
- REG_AW, 5, register-address width; register 0 hard-wired to zero
- PERF_W, 16, stall-counter width, saturating

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock; fixed polarity and synchronicity
- if_valid  in  1  IF/ID holds a real instruction
- if_pc  in  32  PC of instruction in ID
- if_instr  in  32  instruction in ID
- wb_we / wb_addr / wb_data / wb_pc  in  1/REG_AW/DATA_W/32  register write port (wb_pc for write log only)
- ex_dst  in  REG_AW  destination of instruction now in EX (0 = none)
- ex_is_load  in  1  EX instruction is a load
- mem_dst  in  REG_AW  destination of instruction now in MEM
- mem_is_load  in  1  MEM instruction is a load
- mem_fwd_data  in  DATA_W  ALU result in MEM, forwardable when mem_dst≠0 and !mem_is_load
- flush  in  1  kill ID/EX content (exception/redirect from later stage)
- id_stall  out  1  hold PC and IF/ID this cycle (combinational)
- redirect / redirect_pc  out  1/32  taken branch/jump and its target (combinational, gated by !id_stall & if_valid)
- ex_valid, ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm  out  1/32/32/DATA_W/DATA_W/DATA_W  registered ID/EX outputs
- stall_count  out  PERF_W  saturating count of stall cycles

## Operation
- Decode fields: rs=[25:21], rt=[20:16], imm=[15:0], index=[25:0].
- Immediate extension: zero-extend for opcodes 0x0C/0x0D/0x0E; sign-extend otherwise.
- Operand read: regfile value, with WB write-through (wb_we & wb_addr==addr & addr≠0 → wb_data). MEM forward overrides it when mem_dst==addr, addr≠0 and !mem_is_load. Register 0 always reads 0.
- Branches: beq(04), bne(05), blez(06), bgtz(07), bltz/bgez (01, rt=0/1), all compared signed on forwarded operands.
- Branch target = pc+4 + (sext(imm)<<2).
- Jumps: j(02), jal(03) → {pc4[31:28], index, 2'b00}; jr/jalr (opcode 0, funct 08/09) → rs value.
- Delay slot is not flushed on redirect.
- Operand use: rs for all except j/jal/lui; rt for R-type, beq/bne, stores.
- Hazard → id_stall=1 when if_valid and any of:
  - ex_is_load & ex_dst matches a used operand;
  - branch/jr/jalr operand matches ex_dst (any write);
  - branch/jr/jalr operand matches mem_dst with mem_is_load.
  - ex_dst or mem_dst equal to 0 never matches.
- ID/EX update on each clk, in priority order:
  - reset → all zero;
  - flush → ex_valid=0, other fields zero;
  - id_stall → bubble (ex_valid=0, fields zero);
  - else capture (ex_valid=if_valid).
- stall_count increments each cycle id_stall=1, saturates at all-ones, cleared by reset only.

## Timing
- Decode, forward, hazard and redirect are same-cycle combinational. ID/EX latency is 1 clock.
- After reset: ex_valid=0, ex_* =0, stall_count=0, all registers 0. id_stall and redirect follow inputs (0 while if_valid=0).
- Load-use stalls exactly 1 cycle. Branch-on-EX-ALU stalls 1 cycle. Branch-on-EX-load stalls 2 cycles.
- flush and id_stall in the same cycle: flush wins; id_stall still asserted.
- WB write and ID read of the same register in the same cycle: the new value is seen.
- Reset mid-stall: next cycle ex_valid=0 and stall_count=0.

## Structure
- Shared package: opcode/funct constants, branch-kind enum (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J, JR, NONE), extension-mode constant.
- Sub-module regfile_bypass (2R/1W, parametrised DATA_W/REG_AW, write-through, synchronous reset, write log using wb_pc).
- Hazard and branch logic stay inline.

## Test plan
- beq $1,$2 with $1=$2=5, pc=0x3000, imm=4 → redirect=1, redirect_pc=0x3014; next-cycle ex_valid=1.
- lw $3 in EX (ex_is_load=1, ex_dst=3), ID add $4,$3,$5 → id_stall=1 one cycle, ex_valid=0, stall_count=1. Next cycle no stall.
- mem_dst=7, mem_fwd_data=0xDEAD; ID jr $7 → redirect_pc=0xDEAD, no stall. Same with mem_is_load=1 → stall.
- bgtz $6 with $6=0xFFFFFFFF → redirect=0 (signed). bltz → redirect=1.
- wb_we, wb_addr=0, wb_data=9; read $0 → 0. wb_addr=8 same cycle as read of $8 → 9 forwarded.
- Hold a stall 2^PERF_W+3 cycles → stall_count saturates at all-ones. flush during a non-stalled cycle → ex_valid=0.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe_pkg
//  Description : Shared opcode/funct constants, branch-kind and immediate
//                extension types for the MIPS instruction-decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
package id_stage_pipe_pkg;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_REGIMM = 6'h01;
    localparam logic [5:0] c_OP_J      = 6'h02;
    localparam logic [5:0] c_OP_JAL    = 6'h03;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_BNE    = 6'h05;
    localparam logic [5:0] c_OP_BLEZ   = 6'h06;
    localparam logic [5:0] c_OP_BGTZ   = 6'h07;
    localparam logic [5:0] c_OP_ANDI   = 6'h0C;
    localparam logic [5:0] c_OP_ORI    = 6'h0D;
    localparam logic [5:0] c_OP_XORI   = 6'h0E;
    localparam logic [5:0] c_OP_LUI    = 6'h0F;
    localparam logic [5:0] c_OP_SB     = 6'h28;
    localparam logic [5:0] c_OP_SH     = 6'h29;
    localparam logic [5:0] c_OP_SW     = 6'h2B;

    // R-type funct codes handled in ID
    localparam logic [5:0] c_FN_JR     = 6'h08;
    localparam logic [5:0] c_FN_JALR   = 6'h09;

    typedef enum logic [3:0] {
        BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_J, BR_JR, BR_NONE
    } br_kind_e;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic ext_mode_e ext_mode(input logic [5:0] op);
        return (op == c_OP_ANDI || op == c_OP_ORI || op == c_OP_XORI) ? EXT_ZERO : EXT_SIGN;
    endfunction

    // Classify control-transfer instructions resolved in ID.
    function automatic br_kind_e decode_branch(input logic [5:0] op,
                                               input logic [4:0] rt,
                                               input logic [5:0] funct);
        br_kind_e k;
        k = BR_NONE;
        case (op)
            c_OP_BEQ:    k = BR_BEQ;
            c_OP_BNE:    k = BR_BNE;
            c_OP_BLEZ:   k = BR_BLEZ;
            c_OP_BGTZ:   k = BR_BGTZ;
            c_OP_REGIMM: k = (rt == 5'd0) ? BR_BLTZ : ((rt == 5'd1) ? BR_BGEZ : BR_NONE);
            c_OP_J,
            c_OP_JAL:    k = BR_J;
            c_OP_RTYPE:  k = (funct == c_FN_JR || funct == c_FN_JALR) ? BR_JR : BR_NONE;
            default:     k = BR_NONE;
        endcase
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_pipe_regfile_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_bypass
//  Description : 2-read/1-write register file, register 0 hard-wired to zero,
//                same-cycle write-through to both read ports, and a record of
//                the most recent write (address, data, writer PC).
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [31:0]       i_wpc,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic              o_log_valid,
    output logic [REG_AW-1:0] o_log_addr,
    output logic [DATA_W-1:0] o_log_data,
    output logic [31:0]       o_log_pc
);

    localparam int c_NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic              r_log_valid;
    logic [REG_AW-1:0] r_log_addr;
    logic [DATA_W-1:0] r_log_data;
    logic [31:0]       r_log_pc;

    logic w_wr_en;
    assign w_wr_en = i_we && (i_waddr != '0);

    // Register array update; register 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Last-write record, tagged with the PC of the retiring instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_log_valid <= 1'b0;
            r_log_addr  <= '0;
            r_log_data  <= '0;
            r_log_pc    <= '0;
        end else if (w_wr_en) begin
            r_log_valid <= 1'b1;
            r_log_addr  <= i_waddr;
            r_log_data  <= i_wdata;
            r_log_pc    <= i_wpc;
        end
    end

    // Read port A with write-through of a same-cycle write.
    always_comb begin
        o_rdata_a = '0;
        if (i_raddr_a != '0)
            o_rdata_a = (w_wr_en && i_waddr == i_raddr_a) ? i_wdata : r_regs[i_raddr_a];
    end

    // Read port B with write-through of a same-cycle write.
    always_comb begin
        o_rdata_b = '0;
        if (i_raddr_b != '0)
            o_rdata_b = (w_wr_en && i_waddr == i_raddr_b) ? i_wdata : r_regs[i_raddr_b];
    end

    assign o_log_valid = r_log_valid;
    assign o_log_addr  = r_log_addr;
    assign o_log_data  = r_log_data;
    assign o_log_pc    = r_log_pc;

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pipe
//  Description : MIPS instruction-decode stage: decode, register read with
//                WB write-through and MEM forwarding, load-use / branch
//                hazard detection, branch and jump resolution in ID, ID/EX
//                pipeline register and saturating stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_instr,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [31:0]       wb_pc,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_is_load,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              flush,
    output logic              id_stall,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_instr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [PERF_W-1:0] stall_count
);

    // ---------------- decode ----------------
    logic [5:0]        w_op, w_funct;
    logic [REG_AW-1:0] w_rs, w_rt;
    logic [15:0]       w_imm16;
    logic [25:0]       w_index;
    logic [31:0]       w_pc4;
    br_kind_e          w_kind;

    assign w_op    = if_instr[31:26];
    assign w_funct = if_instr[5:0];
    assign w_rs    = REG_AW'(if_instr[25:21]);
    assign w_rt    = REG_AW'(if_instr[20:16]);
    assign w_imm16 = if_instr[15:0];
    assign w_index = if_instr[25:0];
    assign w_pc4   = if_pc + 32'd4;
    assign w_kind  = decode_branch(w_op, if_instr[20:16], w_funct);

    logic [DATA_W-1:0] w_imm;
    assign w_imm = (ext_mode(w_op) == EXT_ZERO) ? {{(DATA_W-16){1'b0}}, w_imm16}
                                                : {{(DATA_W-16){w_imm16[15]}}, w_imm16};

    // ---------------- operand read ----------------
    logic [DATA_W-1:0] w_rf_rs, w_rf_rt, w_rs_val, w_rt_val;
    logic              w_log_valid;
    logic [REG_AW-1:0] w_log_addr;
    logic [DATA_W-1:0] w_log_data;
    logic [31:0]       w_log_pc;

    regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk        (clk),
        .rst        (reset),
        .i_we       (wb_we),
        .i_waddr    (wb_addr),
        .i_wdata    (wb_data),
        .i_wpc      (wb_pc),
        .i_raddr_a  (w_rs),
        .o_rdata_a  (w_rf_rs),
        .i_raddr_b  (w_rt),
        .o_rdata_b  (w_rf_rt),
        .o_log_valid(w_log_valid),
        .o_log_addr (w_log_addr),
        .o_log_data (w_log_data),
        .o_log_pc   (w_log_pc)
    );

    logic w_mem_fwd_ok;
    assign w_mem_fwd_ok = (mem_dst != '0) && !mem_is_load;

    // MEM-stage ALU result overrides the register file (incl. write-through).
    always_comb begin
        w_rs_val = w_rf_rs;
        w_rt_val = w_rf_rt;
        if (w_mem_fwd_ok && mem_dst == w_rs) w_rs_val = mem_fwd_data;
        if (w_mem_fwd_ok && mem_dst == w_rt) w_rt_val = mem_fwd_data;
    end

    // ---------------- hazards ----------------
    logic w_use_rs, w_use_rt, w_br_rs, w_br_rt;
    assign w_use_rs = !(w_op == c_OP_J || w_op == c_OP_JAL || w_op == c_OP_LUI);
    assign w_use_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_BEQ) || (w_op == c_OP_BNE) ||
                      (w_op == c_OP_SB) || (w_op == c_OP_SH) || (w_op == c_OP_SW);
    // Operands that the ID-stage comparator / jump-register path consumes.
    assign w_br_rs  = !(w_kind == BR_NONE || w_kind == BR_J);
    assign w_br_rt  = (w_kind == BR_BEQ) || (w_kind == BR_BNE);

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
    assign w_ex_rs  = (ex_dst  != '0) && (ex_dst  == w_rs);
    assign w_ex_rt  = (ex_dst  != '0) && (ex_dst  == w_rt);
    assign w_mem_rs = (mem_dst != '0) && (mem_dst == w_rs);
    assign w_mem_rt = (mem_dst != '0) && (mem_dst == w_rt);

    logic w_load_use, w_br_ex, w_br_mem;
    assign w_load_use = ex_is_load && ((w_use_rs && w_ex_rs) || (w_use_rt && w_ex_rt));
    assign w_br_ex    = (w_br_rs && w_ex_rs) || (w_br_rt && w_ex_rt);
    assign w_br_mem   = mem_is_load && ((w_br_rs && w_mem_rs) || (w_br_rt && w_mem_rt));
    assign id_stall   = if_valid && (w_load_use || w_br_ex || w_br_mem);

    // ---------------- branch / jump resolution ----------------
    logic        w_taken, w_rs_neg, w_rs_zero;
    logic [31:0] w_target;
    assign w_rs_neg  = w_rs_val[DATA_W-1];
    assign w_rs_zero = (w_rs_val == '0);

    // Condition evaluation (signed) and target selection per branch kind.
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
        case (w_kind)
            BR_BEQ:  w_taken = (w_rs_val == w_rt_val);
            BR_BNE:  w_taken = (w_rs_val != w_rt_val);
            BR_BLEZ: w_taken = w_rs_neg || w_rs_zero;
            BR_BGTZ: w_taken = !w_rs_neg && !w_rs_zero;
            BR_BLTZ: w_taken = w_rs_neg;
            BR_BGEZ: w_taken = !w_rs_neg;
            BR_J: begin
                w_taken  = 1'b1;
                w_target = {w_pc4[31:28], w_index, 2'b00};
            end
            BR_JR: begin
                w_taken  = 1'b1;
                w_target = 32'(w_rs_val);
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign redirect    = if_valid && !id_stall && w_taken;
    assign redirect_pc = redirect ? w_target : 32'd0;

    // ---------------- ID/EX register and stall counter ----------------
    logic              r_ex_valid, w_ex_valid_nxt;
    logic [31:0]       r_ex_pc, w_ex_pc_nxt, r_ex_instr, w_ex_instr_nxt;
    logic [DATA_W-1:0] r_ex_rs, w_ex_rs_nxt, r_ex_rt, w_ex_rt_nxt, r_ex_imm, w_ex_imm_nxt;
    logic [PERF_W-1:0] r_stall_cnt, w_stall_cnt_nxt;

    // Next ID/EX content: flush or stall inserts an all-zero bubble.
    always_comb begin
        w_ex_valid_nxt = 1'b0;
        w_ex_pc_nxt    = '0;
        w_ex_instr_nxt = '0;
        w_ex_rs_nxt    = '0;
        w_ex_rt_nxt    = '0;
        w_ex_imm_nxt   = '0;
        if (!flush && !id_stall) begin
            w_ex_valid_nxt = if_valid;
            w_ex_pc_nxt    = if_pc;
            w_ex_instr_nxt = if_instr;
            w_ex_rs_nxt    = w_rs_val;
            w_ex_rt_nxt    = w_rt_val;
            w_ex_imm_nxt   = w_imm;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (id_stall && !(&r_stall_cnt)) w_stall_cnt_nxt = r_stall_cnt + 1'b1;
    end

    // Pipeline register and counter state; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= '0;
            r_ex_instr  <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_imm    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_ex_valid  <= w_ex_valid_nxt;
            r_ex_pc     <= w_ex_pc_nxt;
            r_ex_instr  <= w_ex_instr_nxt;
            r_ex_rs     <= w_ex_rs_nxt;
            r_ex_rt     <= w_ex_rt_nxt;
            r_ex_imm    <= w_ex_imm_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_instr    = r_ex_instr;
    assign ex_rs_data  = r_ex_rs;
    assign ex_rt_data  = r_ex_rt;
    assign ex_imm      = r_ex_imm;
    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage_pipe
//  Description : Directed self-checking bench for id_stage_pipe with a
//                behavioural reference model of the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int PERF_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_valid;
    logic [31:0]       if_pc, if_instr;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       wb_pc;
    logic [REG_AW-1:0] ex_dst, mem_dst;
    logic              ex_is_load, mem_is_load, flush;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              id_stall, redirect, ex_valid;
    logic [31:0]       redirect_pc, ex_pc, ex_instr;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [PERF_W-1:0] stall_count;

    id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load), .mem_dst(mem_dst), .mem_is_load(mem_is_load),
        .mem_fwd_data(mem_fwd_data), .flush(flush), .id_stall(id_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction
    function automatic logic [31:0] j_type(input int op, input int idx);
        return {op[5:0], idx[25:0]};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [PERF_W-1:0] m_cnt;
    logic        m_v;
    logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
    bit          m_ready = 0;

    // Architectural register value as seen by ID this cycle.
    function automatic logic [31:0] rd_reg(input int a);
        if (a == 0) return 32'd0;
        if (mem_dst == a[4:0] && !mem_is_load) return mem_fwd_data;
        if (wb_we && wb_addr == a[4:0]) return wb_data;
        return m_regs[a];
    endfunction

    function automatic void model_id(output logic st, output logic rd, output logic [31:0] tgt,
                                     output logic [31:0] rsv, output logic [31:0] rtv,
                                     output logic [31:0] imm);
        int op, rs, rt, fn;
        bit uses_rs, uses_rt, cmp_rs, cmp_rt, taken;
        int srs;
        op = int'(if_instr[31:26]); rs = int'(if_instr[25:21]);
        rt = int'(if_instr[20:16]); fn = int'(if_instr[5:0]);
        rsv = rd_reg(rs);
        rtv = rd_reg(rt);
        srs = $signed(rsv);
        imm = (op == 12 || op == 13 || op == 14) ? {16'd0, if_instr[15:0]}
                                                 : {{16{if_instr[15]}}, if_instr[15:0]};
        taken = 0; cmp_rs = 0; cmp_rt = 0;
        tgt = if_pc + 4 + (imm << 2);
        case (op)
            4: begin taken = (rsv == rtv); cmp_rs = 1; cmp_rt = 1; end
            5: begin taken = (rsv != rtv); cmp_rs = 1; cmp_rt = 1; end
            6: begin taken = (srs <= 0); cmp_rs = 1; end
            7: begin taken = (srs > 0);  cmp_rs = 1; end
            1: if (rt == 0) begin taken = (srs < 0); cmp_rs = 1; end
               else if (rt == 1) begin taken = (srs >= 0); cmp_rs = 1; end
            2, 3: begin taken = 1; tgt = {if_pc[31:28] + ((if_pc[27:0] + 28'd4) < if_pc[27:0] ? 4'd1 : 4'd0),
                                           if_instr[25:0], 2'b00}; end
            0: if (fn == 8 || fn == 9) begin taken = 1; cmp_rs = 1; tgt = rsv; end
            default: ;
        endcase
        uses_rs = !(op == 2 || op == 3 || op == 15);
        uses_rt = (op == 0 || op == 4 || op == 5 || op == 'h28 || op == 'h29 || op == 'h2B);
        st = if_valid && (
             (ex_is_load && ex_dst != 0 && ((uses_rs && ex_dst == rs) || (uses_rt && ex_dst == rt))) ||
             (ex_dst != 0 && ((cmp_rs && ex_dst == rs) || (cmp_rt && ex_dst == rt))) ||
             (mem_is_load && mem_dst != 0 && ((cmp_rs && mem_dst == rs) || (cmp_rt && mem_dst == rt))));
        rd = if_valid && !st && taken;
    endfunction

    // Advance the model's architectural state at each clock.
    always @(posedge clk) begin
        logic st, rd;
        logic [31:0] tgt, rsv, rtv, imm;
        model_id(st, rd, tgt, rsv, rtv, imm);
        if (reset) begin
            m_v = 0; m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_ready = 1;
        end else begin
            if (flush || st) begin
                m_v = 0; m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
            end else begin
                m_v = if_valid; m_pc = if_pc; m_instr = if_instr; m_rs = rsv; m_rt = rtv; m_imm = imm;
            end
            if (st && m_cnt != {PERF_W{1'b1}}) m_cnt = m_cnt + 1;
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
        end
    end

    // Compare every DUT output with the model, away from the active edge.
    always @(negedge clk) begin
        logic st, rd;
        logic [31:0] tgt, rsv, rtv, imm;
        if (m_ready) begin
            model_id(st, rd, tgt, rsv, rtv, imm);
            chk("id_stall", 64'(id_stall), 64'(st));
            chk("redirect", 64'(redirect), 64'(rd));
            if (rd) chk("redirect_pc", 64'(redirect_pc), 64'(tgt));
            chk("ex_valid", 64'(ex_valid), 64'(m_v));
            chk("ex_pc", 64'(ex_pc), 64'(m_pc));
            chk("ex_instr", 64'(ex_instr), 64'(m_instr));
            chk("ex_rs_data", 64'(ex_rs_data), 64'(m_rs));
            chk("ex_rt_data", 64'(ex_rt_data), 64'(m_rt));
            chk("ex_imm", 64'(ex_imm), 64'(m_imm));
            chk("stall_count", 64'(stall_count), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_we = 1; wb_addr = a[4:0]; wb_data = d; wb_pc = 32'h0000_0F00 + a;
        tick();
        wb_we = 0;
    endtask

    // Directed stimulus with hand-computed literal expectations.
    initial begin
        reset = 1; if_valid = 0; if_pc = 0; if_instr = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        wb_pc = 0; ex_dst = 0; ex_is_load = 0; mem_dst = 0; mem_is_load = 0; mem_fwd_data = 0;
        flush = 0;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("lit_reset_ex_valid", 64'(ex_valid), 64'd0);
        chk("lit_reset_stall_count", 64'(stall_count), 64'd0);
        chk("lit_reset_id_stall", 64'(id_stall), 64'd0);
        chk("lit_reset_redirect", 64'(redirect), 64'd0);
        tick();
        wb(1, 5); wb(2, 5); wb(5, 32'h100); wb(6, 32'hFFFF_FFFF);

        // beq $1,$2 taken
        if_valid = 1; if_pc = 32'h3000; if_instr = i_type(4, 1, 2, 4);
        @(negedge clk);
        chk("lit_beq_redirect", 64'(redirect), 64'd1);
        chk("lit_beq_target", 64'(redirect_pc), 64'h3014);
        tick();
        if_valid = 0;
        @(negedge clk);
        chk("lit_beq_ex_valid", 64'(ex_valid), 64'd1);
        tick();

        // load-use on $3
        if_valid = 1; if_pc = 32'h3004; if_instr = r_type(3, 5, 4, 'h20);
        ex_is_load = 1; ex_dst = 3;
        @(negedge clk);
        chk("lit_loaduse_stall", 64'(id_stall), 64'd1);
        tick();
        ex_is_load = 0; ex_dst = 0;
        @(negedge clk);
        chk("lit_loaduse_nostall", 64'(id_stall), 64'd0);
        chk("lit_loaduse_bubble", 64'(ex_valid), 64'd0);
        chk("lit_loaduse_count", 64'(stall_count), 64'd1);
        tick();

        // jr $7 with MEM forward, then MEM load
        if_instr = r_type(7, 0, 0, 8); mem_dst = 7; mem_fwd_data = 32'hDEAD;
        @(negedge clk);
        chk("lit_jr_target", 64'(redirect_pc), 64'hDEAD);
        chk("lit_jr_nostall", 64'(id_stall), 64'd0);
        tick();
        mem_is_load = 1;
        @(negedge clk);
        chk("lit_jr_memload_stall", 64'(id_stall), 64'd1);
        tick();
        mem_is_load = 0; mem_dst = 0;

        // signed compares on $6 = -1
        if_pc = 32'h100; if_instr = i_type(7, 6, 0, 2);
        @(negedge clk);
        chk("lit_bgtz_neg", 64'(redirect), 64'd0);
        tick();
        if_instr = i_type(1, 6, 0, 2);
        @(negedge clk);
        chk("lit_bltz_neg", 64'(redirect), 64'd1);
        chk("lit_bltz_target", 64'(redirect_pc), 64'h10C);
        tick();
        if_instr = i_type(1, 6, 1, 2); tick();          // bgez not taken
        if_instr = i_type(6, 0, 0, -3); tick();         // blez $0 taken, backward

        // j keeps upper PC bits
        if_pc = 32'h4000_0010; if_instr = j_type(2, 'h40);
        @(negedge clk);
        chk("lit_j_target", 64'(redirect_pc), 64'h4000_0100);
        tick();

        // immediate extension
        if_pc = 32'h200; if_instr = i_type('h0D, 1, 4, 'h8000);
        tick();
        if_instr = i_type(8, 1, 4, 'h8000);
        @(negedge clk);
        chk("lit_ori_zext", 64'(ex_imm), 64'h0000_8000);
        tick();
        if_valid = 0;
        @(negedge clk);
        chk("lit_addi_sext", 64'(ex_imm), 64'hFFFF_8000);
        tick();

        // $0 write ignored; same-cycle write-through
        if_valid = 1; if_instr = r_type(0, 8, 9, 'h20);
        wb_we = 1; wb_addr = 0; wb_data = 9;
        tick();
        wb_addr = 8;
        @(negedge clk);
        chk("lit_r0_read", 64'(ex_rs_data), 64'd0);
        tick();
        wb_we = 0;
        @(negedge clk);
        chk("lit_wb_through", 64'(ex_rt_data), 64'd9);
        tick();

        // branch on EX ALU result: one stall
        if_instr = i_type(4, 1, 2, 4); ex_dst = 1;
        @(negedge clk);
        chk("lit_br_exalu_stall", 64'(id_stall), 64'd1);
        tick();
        ex_dst = 0; tick();
        // branch on EX load: two stalls
        ex_dst = 2; ex_is_load = 1; tick();
        ex_dst = 0; ex_is_load = 0; mem_dst = 2; mem_is_load = 1;
        @(negedge clk);
        chk("lit_br_load_stall2", 64'(id_stall), 64'd1);
        tick();
        mem_dst = 0; mem_is_load = 0;
        @(negedge clk);
        chk("lit_br_load_release", 64'(redirect), 64'd1);
        tick();

        // flush on a non-stalled cycle
        if_instr = r_type(1, 2, 3, 'h20); flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("lit_flush_bubble", 64'(ex_valid), 64'd0);
        tick();

        // flush together with a stall, then reset mid-stall
        if_instr = r_type(3, 5, 4, 'h20); ex_is_load = 1; ex_dst = 3; flush = 1;
        @(negedge clk);
        chk("lit_flush_stall", 64'(id_stall), 64'd1);
        tick();
        flush = 0; reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("lit_rst_midstall_count", 64'(stall_count), 64'd0);
        chk("lit_rst_midstall_valid", 64'(ex_valid), 64'd0);

        // saturation of the stall counter
        repeat ((1 << PERF_W) + 3) tick();
        @(negedge clk);
        chk("lit_count_saturated", 64'(stall_count), 64'(255));
        tick();
        ex_is_load = 0; ex_dst = 0; if_valid = 0;
        tick(); tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
